btb: RTL and testbench
======================

Name: btb

Overview:
- 2-way set-associative branch target buffer and next-PC selector in IF, beside the tournament direction predictor.
- In IF, looks up the fetch PC and combines a hit with the predictor's br_take to choose next_pc.
- Carries prediction metadata through ID and EX, honouring stall_id and stall_ex.
- In EX, checks the prediction against the resolved outcome, raises redirect with the correct PC, and trains the table.

Parameters:
s_set_idx, 4, log2 of set count (16 sets)
s_pc_offset, 2, low PC bits ignored for index/tag (word-aligned fetch)
s_tag, 32-s_set_idx-s_pc_offset, tag width (derived, do not override)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
stall_id  input  1  hold ID-stage metadata register
stall_ex  input  1  hold EX-stage metadata register
addr  input  32  IF fetch PC
br_take  input  1  direction prediction for addr, same cycle
update  input  1  valid control-transfer instr resolved in EX; at most one cycle per instr
br_en  input  1  actual taken in EX (1 for jal/jalr)
ex_target  input  32  actual target in EX
pred_taken  output  1  IF predicted taken (hit & br_take)
next_pc  output  32  PC to fetch next cycle
redirect  output  1  EX misprediction; pipeline flushes IF/ID
redirect_pc  output  32  correct PC when redirect=1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports clk, rst.
- Address split: set = addr[s_set_idx+s_pc_offset-1:s_pc_offset]; tag = addr[31:s_set_idx+s_pc_offset].
- Entry: valid, tag, target[31:0]. Plus one LRU bit per set naming the way to replace next.
- IF lookup (combinational):
  - hit = a valid way whose tag equals the addr tag; hit_way = that way.
  - If both ways match (must not occur), way 0 wins.
  - pred_taken = hit & br_take.
  - pred_target = target of hit_way.
- next_pc priority: redirect ? redirect_pc : pred_taken ? pred_target : addr+4. All 32-bit adds wrap modulo 2^32.
- No write-to-read bypass: a write on edge N is visible to a lookup in cycle N+1.
- Metadata package (pc, hit, hit_way, pred_taken, pred_target) moves IF->ID->EX:
  - each register loads the previous stage's package unless its stall is high, in which case it holds.
  - stall_id=1 with stall_ex=0 still advances the ID package into EX.
- EX check (combinational), using the EX package:
  - dir_wrong = br_en != pred_taken.
  - tgt_wrong = br_en & pred_taken & (pred_target != ex_target).
  - redirect = update & (dir_wrong | tgt_wrong).
  - redirect_pc = br_en ? ex_target : pc+4.
  - redirect_pc is don't-care when redirect=0.
- Training on the clock edge when update=1:
  - br_en=1, package hit=1: rewrite that way's target with ex_target; keep tag.
  - br_en=1, package hit=0: allocate a way. Use the lowest-numbered invalid way, else the LRU way. Write valid=1, the pc tag, and ex_target.
  - br_en=1, either case: set LRU = ~written way.
  - br_en=0: no table or LRU change. Entries survive not-taken outcomes.
  - update=0: table unchanged.
- IF hits never touch LRU.
- Training uses the pc carried in the package, not addr.
- Writes occur regardless of stall_ex; the pipeline guarantees update is a single-cycle pulse per instruction.
- Reset:
  - all valid=0 and all LRU=0; every package register cleared (hit=0, pred_taken=0, pc=0).
  - redirect forced to 0 while rst=1.
  - next_pc = addr+4 after reset (no hits possible).
- Reset mid-operation: every entry is invalidated on that edge; an update in the same cycle is discarded.
- Wrong-path packages need no flushing: the pipeline deasserts update for squashed instructions.

Decomposition:
- Shared package rv32i_types:
  - btb_entry_t struct (valid, tag, target).
  - btb_pkg_t metadata struct.
- Sub-module btb_array: tag/target/valid/LRU storage with a combinational two-way compare and one write port (set, way, tag, target, we).
- The top module keeps the pipeline registers, EX check, allocation choice, and next_pc mux.

Test Plan:
1. After reset, addr=0x0000_0040, br_take=1 -> pred_taken=0, next_pc=0x0000_0044, redirect=0.
2. Cold taken branch:
   - Stimulus: branch at 0x100 reaches EX with hit=0; update=1, br_en=1, ex_target=0x200.
   - Response: redirect=1, redirect_pc=0x200.
   - Then: refetch 0x100 with br_take=1 -> pred_taken=1, next_pc=0x200.
3. Target change: trained 0x100->0x200, EX resolves taken to 0x300 -> redirect=1, redirect_pc=0x300. Next lookup of 0x100 gives next_pc=0x300 with no new allocation.
4. Predicted taken, actually not taken: 0x100 predicted to 0x200, EX br_en=0 -> redirect=1, redirect_pc=0x104. Entry retained; next lookup still hits.
5. Replacement in set 0:
   - Train 0x000, then 0x040, then 0x080, all taken.
   - Response: 0x080 replaces 0x000 (LRU).
   - Then: lookup 0x000 misses; lookups 0x040 and 0x080 hit.
6. Stalls:
   - Stimulus: stall_ex=1 for 3 cycles with a predicted-taken package in EX; then update=1, br_en=1, ex_target equal to the predicted target.
   - Response: redirect=0; the EX package is unchanged throughout the stall.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the branch target buffer.
//   s_set_idx   : log2 of the set count
//   s_pc_offset : low PC bits ignored for index/tag (word-aligned fetch)
//   s_tag       : tag width, derived from the two above
//   btb_entry_t : one way of one set (valid, tag, target)
//   btb_pkg_t   : prediction metadata carried IF -> ID -> EX
package rv32i_types;

  localparam int unsigned s_set_idx   = 4;
  localparam int unsigned s_pc_offset = 2;
  localparam int unsigned s_tag       = 32 - s_set_idx - s_pc_offset;
  localparam int unsigned s_sets      = 1 << s_set_idx;

  typedef struct packed {
    logic             valid;
    logic [s_tag-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        hit_way;
    logic        pred_taken;
    logic [31:0] pred_target;
  } btb_pkg_t;

endpackage

// File: rtl/btb_array.sv
// Two-way tag/target/valid storage with one LRU bit per set.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset (invalidates all)
//   i_rd_set, i_rd_tag    : IF lookup key
//   o_hit, o_hit_way      : lookup result (way 0 wins if both match)
//   o_hit_target          : target stored in the hitting way
//   i_wr_set              : set used by the write port; also read for allocation
//   o_wr_valid, o_wr_lru  : valid bits and LRU bit of i_wr_set
//   i_we, i_wr_way        : write enable and destination way
//   i_wr_tag_en, i_wr_tag : tag is only rewritten on allocation
//   i_wr_target           : target to store
module btb_array
  import rv32i_types::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [s_set_idx-1:0] i_rd_set,
  input  logic [s_tag-1:0]     i_rd_tag,
  output logic                 o_hit,
  output logic                 o_hit_way,
  output logic [31:0]          o_hit_target,
  input  logic [s_set_idx-1:0] i_wr_set,
  output logic [1:0]           o_wr_valid,
  output logic                 o_wr_lru,
  input  logic                 i_we,
  input  logic                 i_wr_way,
  input  logic                 i_wr_tag_en,
  input  logic [s_tag-1:0]     i_wr_tag,
  input  logic [31:0]          i_wr_target
);

  btb_entry_t              r_entry [2][s_sets];
  logic       [s_sets-1:0] r_lru;
  logic       [1:0]        w_match;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      w_match[w] = r_entry[w][i_rd_set].valid && (r_entry[w][i_rd_set].tag == i_rd_tag);
    end
    o_hit        = |w_match;
    o_hit_way    = ~w_match[0];
    o_hit_target = r_entry[o_hit_way][i_rd_set].target;
    o_wr_valid   = {r_entry[1][i_wr_set].valid, r_entry[0][i_wr_set].valid};
    o_wr_lru     = r_lru[i_wr_set];
  end

  // Reset has priority, so an update coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < s_sets; s++) begin
          r_entry[w][s] <= '0;
        end
      end
      r_lru <= '0;
    end else if (i_we) begin
      r_entry[i_wr_way][i_wr_set].valid  <= 1'b1;
      r_entry[i_wr_way][i_wr_set].target <= i_wr_target;
      if (i_wr_tag_en) begin
        r_entry[i_wr_way][i_wr_set].tag <= i_wr_tag;
      end
      r_lru[i_wr_set] <= ~i_wr_way;
    end
  end

endmodule

// File: rtl/btb.sv
// Branch target buffer and next-PC selector.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall_id, stall_ex  : hold the ID / EX metadata registers
//   addr, br_take       : IF fetch PC and direction prediction for it
//   update, br_en       : EX resolution valid, actual taken
//   ex_target           : actual target in EX
//   pred_taken, next_pc : IF prediction and PC to fetch next
//   redirect            : EX misprediction
//   redirect_pc         : correct PC when redirect is high
module btb
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        stall_ex,
  input  logic [31:0] addr,
  input  logic        br_take,
  input  logic        update,
  input  logic        br_en,
  input  logic [31:0] ex_target,
  output logic        pred_taken,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic                 w_hit;
  logic                 w_hit_way;
  logic [31:0]          w_hit_target;
  logic [1:0]           w_wr_valid;
  logic                 w_wr_lru;
  logic                 w_wr_way;
  logic                 w_we;
  logic                 w_dir_wrong;
  logic                 w_tgt_wrong;
  logic [s_set_idx-1:0] w_rd_set;
  logic [s_tag-1:0]     w_rd_tag;
  logic [s_set_idx-1:0] w_wr_set;
  logic [s_tag-1:0]     w_wr_tag;
  btb_pkg_t             w_if_pkg;
  btb_pkg_t             r_id_pkg;
  btb_pkg_t             r_ex_pkg;

  assign w_rd_set = addr[s_set_idx+s_pc_offset-1:s_pc_offset];
  assign w_rd_tag = addr[31:s_set_idx+s_pc_offset];
  // Training indexes with the PC that travelled with the instruction.
  assign w_wr_set = r_ex_pkg.pc[s_set_idx+s_pc_offset-1:s_pc_offset];
  assign w_wr_tag = r_ex_pkg.pc[31:s_set_idx+s_pc_offset];

  btb_array u_array (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rd_set     (w_rd_set),
    .i_rd_tag     (w_rd_tag),
    .o_hit        (w_hit),
    .o_hit_way    (w_hit_way),
    .o_hit_target (w_hit_target),
    .i_wr_set     (w_wr_set),
    .o_wr_valid   (w_wr_valid),
    .o_wr_lru     (w_wr_lru),
    .i_we         (w_we),
    .i_wr_way     (w_wr_way),
    .i_wr_tag_en  (~r_ex_pkg.hit),
    .i_wr_tag     (w_wr_tag),
    .i_wr_target  (ex_target)
  );

  always_comb begin
    pred_taken           = w_hit & br_take;
    w_if_pkg.pc          = addr;
    w_if_pkg.hit         = w_hit;
    w_if_pkg.hit_way     = w_hit_way;
    w_if_pkg.pred_taken  = pred_taken;
    w_if_pkg.pred_target = w_hit_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pkg <= '0;
      r_ex_pkg <= '0;
    end else begin
      if (!stall_id) r_id_pkg <= w_if_pkg;
      if (!stall_ex) r_ex_pkg <= r_id_pkg;
    end
  end

  always_comb begin
    w_dir_wrong = br_en != r_ex_pkg.pred_taken;
    w_tgt_wrong = br_en & r_ex_pkg.pred_taken & (r_ex_pkg.pred_target != ex_target);
    redirect    = ~rst & update & (w_dir_wrong | w_tgt_wrong);
    redirect_pc = br_en ? ex_target : r_ex_pkg.pc + 32'd4;
  end

  // Hit: retrain the same way. Miss: lowest invalid way, else the LRU way.
  always_comb begin
    w_we = update & br_en;
    if (r_ex_pkg.hit)        w_wr_way = r_ex_pkg.hit_way;
    else if (!w_wr_valid[0]) w_wr_way = 1'b0;
    else if (!w_wr_valid[1]) w_wr_way = 1'b1;
    else                     w_wr_way = w_wr_lru;
  end

  always_comb begin
    if (redirect)        next_pc = redirect_pc;
    else if (pred_taken) next_pc = w_hit_target;
    else                 next_pc = addr + 32'd4;
  end

endmodule

// File: tb/tb_btb.sv
// Self-checking bench for btb: directed scenarios followed by random branches,
// checked against a plain array model of the two-way table.
module tb_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id;
  logic        stall_ex;
  logic [31:0] addr;
  logic        br_take;
  logic        update;
  logic        br_en;
  logic [31:0] ex_target;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  // Reference table: 16 sets, 2 ways.
  logic        m_valid [2][16];
  logic [25:0] m_tag   [2][16];
  logic [31:0] m_tgt   [2][16];
  logic        m_lru   [16];

  always #5 clk = ~clk;

  btb dut (
    .clk         (clk),
    .rst         (rst),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .addr        (addr),
    .br_take     (br_take),
    .update      (update),
    .br_en       (br_en),
    .ex_target   (ex_target),
    .pred_taken  (pred_taken),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 16; s++) begin
        m_valid[w][s] = 1'b0;
        m_tag[w][s]   = '0;
        m_tgt[w][s]   = '0;
      end
    end
    for (int s = 0; s < 16; s++) m_lru[s] = 1'b0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic hit, output logic way,
                          output logic [31:0] tgt);
    int s;
    s   = int'(pc[5:2]);
    hit = 1'b0;
    way = 1'b0;
    tgt = '0;
    for (int w = 1; w >= 0; w--) begin
      if (m_valid[w][s] && m_tag[w][s] == pc[31:6]) begin
        hit = 1'b1;
        way = w[0];
        tgt = m_tgt[w][s];
      end
    end
  endtask

  task automatic m_train(input logic [31:0] pc, input logic was_hit, input logic hit_way,
                         input logic [31:0] tgt);
    int s;
    int w;
    s = int'(pc[5:2]);
    if (was_hit)             w = int'(hit_way);
    else if (!m_valid[0][s]) w = 0;
    else if (!m_valid[1][s]) w = 1;
    else                     w = int'(m_lru[s]);
    m_valid[w][s] = 1'b1;
    if (!was_hit) m_tag[w][s] = pc[31:6];
    m_tgt[w][s] = tgt;
    m_lru[s]    = (w == 0);
  endtask

  // Fetch addr with br_take=1 and compare against the model.
  task automatic lookup(input logic [31:0] pc);
    logic h, w;
    logic [31:0] t;
    addr    = pc;
    br_take = 1'b1;
    update  = 1'b0;
    #1;
    m_lookup(pc, h, w, t);
    check("lk_pred", {31'd0, pred_taken}, {31'd0, h});
    check("lk_next", next_pc, h ? t : pc + 32'd4);
    tick();
  endtask

  task automatic look_const(input logic [31:0] pc, input logic exp_pred,
                            input logic [31:0] exp_next);
    addr    = pc;
    br_take = 1'b1;
    update  = 1'b0;
    #1;
    check("lc_pred", {31'd0, pred_taken}, {31'd0, exp_pred});
    check("lc_next", next_pc, exp_next);
    tick();
  endtask

  // One branch through IF, ID (optionally stalled in ID) and EX, then train.
  task automatic run_branch(input logic [31:0] pc, input logic bt, input logic be,
                            input logic [31:0] tgt, input logic sid);
    logic h, w, pred, exp_redir;
    logic [31:0] pt, exp_pc;
    addr     = pc;
    br_take  = bt;
    update   = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    #1;
    m_lookup(pc, h, w, pt);
    pred = h & bt;
    check("if_pred", {31'd0, pred_taken}, {31'd0, pred});
    check("if_next", next_pc, pred ? pt : pc + 32'd4);
    tick();
    addr     = $urandom & 32'hffff_fffc;
    br_take  = 1'($urandom);
    stall_id = sid;
    tick();
    stall_id  = 1'b0;
    addr      = $urandom & 32'hffff_fffc;
    update    = 1'b1;
    br_en     = be;
    ex_target = tgt;
    #1;
    exp_redir = (be != pred) | (be & pred & (pt != tgt));
    exp_pc    = be ? tgt : pc + 32'd4;
    check("ex_redirect", {31'd0, redirect}, {31'd0, exp_redir});
    if (exp_redir) begin
      check("ex_redirect_pc", redirect_pc, exp_pc);
      check("ex_next_pc", next_pc, exp_pc);
    end
    tick();
    if (be) m_train(pc, h, w, tgt);
    update = 1'b0;
  endtask

  initial begin
    logic [31:0] pc, tgt;
    m_clear();
    rst       = 1'b1;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    addr      = 32'h0;
    br_take   = 1'b0;
    update    = 1'b1;
    br_en     = 1'b1;
    ex_target = 32'h0000_0800;
    tick();
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    tick();
    rst    = 1'b0;
    update = 1'b0;

    // After reset: no hits.
    addr    = 32'h0000_0040;
    br_take = 1'b1;
    #1;
    check("t1_pred", {31'd0, pred_taken}, 32'd0);
    check("t1_next", next_pc, 32'h0000_0044);
    check("t1_redirect", {31'd0, redirect}, 32'd0);
    tick();

    // Cold taken branch, then target change, then not-taken outcome.
    run_branch(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    look_const(32'h0000_0100, 1'b1, 32'h0000_0200);
    run_branch(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    look_const(32'h0000_0100, 1'b1, 32'h0000_0300);
    run_branch(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0abc, 1'b1);
    look_const(32'h0000_0100, 1'b1, 32'h0000_0300);

    // EX held for 3 cycles with a predicted-taken package for 0x100.
    addr    = 32'h0000_0100;
    br_take = 1'b1;
    tick();
    addr = 32'h0000_0180;
    tick();
    stall_ex = 1'b1;
    stall_id = 1'b1;
    br_en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = $urandom & 32'hffff_fffc;
      #1;
      check("st_redirect", {31'd0, redirect}, 32'd0);
      check("st_pc", redirect_pc, 32'h0000_0104);
      tick();
    end
    stall_ex  = 1'b0;
    stall_id  = 1'b0;
    update    = 1'b1;
    br_en     = 1'b1;
    ex_target = 32'h0000_0300;
    #1;
    check("st_release", {31'd0, redirect}, 32'd0);
    tick();
    update = 1'b0;

    // Reset coinciding with an update: update dropped, table emptied.
    addr    = 32'h0000_0240;
    br_take = 1'b1;
    tick();
    tick();
    rst       = 1'b1;
    update    = 1'b1;
    br_en     = 1'b1;
    ex_target = 32'h0000_0998;
    #1;
    check("rm_redirect", {31'd0, redirect}, 32'd0);
    tick();
    rst    = 1'b0;
    update = 1'b0;
    m_clear();
    look_const(32'h0000_0240, 1'b0, 32'h0000_0244);
    look_const(32'h0000_0100, 1'b0, 32'h0000_0104);

    // Replacement in set 0.
    run_branch(32'h0000_0000, 1'b1, 1'b1, 32'h0000_0500, 1'b0);
    run_branch(32'h0000_0040, 1'b1, 1'b1, 32'h0000_0540, 1'b0);
    run_branch(32'h0000_0080, 1'b1, 1'b1, 32'h0000_0580, 1'b0);
    look_const(32'h0000_0000, 1'b0, 32'h0000_0004);
    look_const(32'h0000_0040, 1'b1, 32'h0000_0540);
    look_const(32'h0000_0080, 1'b1, 32'h0000_0580);

    // Random branches over a small PC pool to force hits and conflicts.
    for (int i = 0; i < 80; i++) begin
      pc  = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2);
      tgt = ($urandom_range(0, 1) == 1) ? 32'h0000_1000 : ($urandom & 32'hffff_fffc);
      run_branch(pc, 1'($urandom), 1'($urandom_range(0, 3) != 0), tgt, 1'($urandom));
      if ((i % 8) == 7) lookup(pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
